// File: rtl/work_ram_arbiter.sv
// -----------------------------------------------------------------------------
// work_ram_arbiter
//
// Shares the single-port work RAM between the game CPU bus and an external
// maintenance requester (e.g. a hiscore save/restore engine). The CPU owns the
// port by default. An external access first pauses the CPU and lets the bus
// settle for PAUSE_SETTLE cycles. It then takes the port for exactly two
// cycles (GRANT, WAIT) and reports completion with a one-cycle ext_ack. After
// the ack the pause is held for HOLD_CYCLES idle cycles, so a following
// request is served without another settle interval.
//
// Handshake (external side): ext_req is a level that is raised with
// ext_we/ext_addr/ext_din stable and held until the cycle in which ext_ack is
// high. ext_ack is a single-cycle completion pulse; ext_dout carries the read
// data while ext_ack is high. If ext_req is still high in the cycle after
// ext_ack, that is a new request. Dropping ext_req before ext_ack does not
// abort the access.
//
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   cpu_addr/din   CPU RAM address / write data
//   cpu_we         CPU write strobe (one cycle per write)
//   cpu_dout       RAM read data to the CPU (combinational from ram_dout)
//   ext_req        external request level
//   ext_we         external access is a write
//   ext_addr/din   external address / write data
//   ext_dout       external read data, valid while ext_ack is high
//   ext_ack        one-cycle completion pulse
//   pause_req      registered CPU pause request
//   ram_addr/din   RAM address / write data
//   ram_we         RAM write enable
//   ram_dout       RAM read data (one-cycle read latency)
//   cpu_conflict   sticky: a CPU write arrived while the external side owned
//                  the port and was discarded
// -----------------------------------------------------------------------------
module work_ram_arbiter #(
   parameter int AW           = 12,
   parameter int DW           = 8,
   parameter int PAUSE_SETTLE = 4,
   parameter int HOLD_CYCLES  = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_din,
   input  logic          cpu_we,
   output logic [DW-1:0] cpu_dout,
   input  logic          ext_req,
   input  logic          ext_we,
   input  logic [AW-1:0] ext_addr,
   input  logic [DW-1:0] ext_din,
   output logic [DW-1:0] ext_dout,
   output logic          ext_ack,
   output logic          pause_req,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_din,
   output logic          ram_we,
   input  logic [DW-1:0] ram_dout,
   output logic          cpu_conflict
);

   // Both intervals are limited to 1..255, so 8-bit counters suffice.
   localparam logic [7:0] SETTLE_LOAD = 8'(PAUSE_SETTLE);
   localparam logic [7:0] HOLD_LOAD   = 8'(HOLD_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_PAUSING = 3'd1,
      S_GRANT   = 3'd2,
      S_WAIT    = 3'd3,
      S_ACK     = 3'd4,
      S_HOLD    = 3'd5
   } state_t;

   state_t        state;
   state_t        state_next;

   logic [7:0]    settle_cnt;
   logic [7:0]    hold_cnt;

   // External request captured on entry to GRANT; the port drives these
   // rather than the live inputs for the whole ownership window.
   logic [AW-1:0] ext_addr_q;
   logic [DW-1:0] ext_din_q;
   logic          ext_we_q;

   logic          ext_owns;
   logic          grant_entry;

   // --------------------------------------------------------------------------
   // State register
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (ext_req) begin
               state_next = S_PAUSING;
            end
         end
         S_PAUSING: begin
            // A count of 1 is the last settle cycle; 0 is only reachable
            // out of reset and is treated the same way.
            if (settle_cnt <= 8'd1) begin
               state_next = S_GRANT;
            end
         end
         S_GRANT: begin
            state_next = S_WAIT;
         end
         S_WAIT: begin
            state_next = S_ACK;
         end
         S_ACK: begin
            // ext_req is deliberately ignored here: it is still the request
            // being acknowledged.
            state_next = S_HOLD;
         end
         S_HOLD: begin
            // A new request wins over the hold timeout, including on the last
            // hold cycle, so the pause never drops between accesses.
            if (ext_req) begin
               state_next = S_GRANT;
            end else if (hold_cnt <= 8'd1) begin
               state_next = S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Output logic
   // --------------------------------------------------------------------------
   always_comb begin
      ext_owns = 1'b0;
      ext_ack  = 1'b0;
      case (state)
         S_GRANT: ext_owns = 1'b1;
         S_WAIT:  ext_owns = 1'b1;
         S_ACK:   ext_ack  = 1'b1;
         default: begin
            ext_owns = 1'b0;
            ext_ack  = 1'b0;
         end
      endcase
   end

   // RAM port mux. The external write strobe is only driven in GRANT; WAIT
   // keeps the external address so the read data lands one cycle later.
   always_comb begin
      ram_addr = cpu_addr;
      ram_din  = cpu_din;
      ram_we   = cpu_we;
      if (ext_owns) begin
         ram_addr = ext_addr_q;
         ram_din  = ext_din_q;
         ram_we   = (state == S_GRANT) ? ext_we_q : 1'b0;
      end
   end

   assign cpu_dout = ram_dout;

   // --------------------------------------------------------------------------
   // Counters
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         settle_cnt <= '0;
      end else if ((state == S_IDLE) && (state_next == S_PAUSING)) begin
         settle_cnt <= SETTLE_LOAD;
      end else if ((state == S_PAUSING) && (settle_cnt != 8'd0)) begin
         settle_cnt <= settle_cnt - 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hold_cnt <= '0;
      end else if (state == S_ACK) begin
         hold_cnt <= HOLD_LOAD;
      end else if ((state == S_HOLD) && !ext_req && (hold_cnt != 8'd0)) begin
         hold_cnt <= hold_cnt - 8'd1;
      end
   end

   // --------------------------------------------------------------------------
   // Request capture, read-data capture, pause and conflict flags
   // --------------------------------------------------------------------------
   assign grant_entry = (state_next == S_GRANT) && (state != S_GRANT);

   always_ff @(posedge clk) begin
      if (reset) begin
         ext_addr_q <= '0;
         ext_din_q  <= '0;
         ext_we_q   <= 1'b0;
      end else if (grant_entry) begin
         ext_addr_q <= ext_addr;
         ext_din_q  <= ext_din;
         ext_we_q   <= ext_we;
      end
   end

   // Read data for the address presented in GRANT is on ram_dout during WAIT.
   // It is held afterwards, so it is stable through ACK for reads and writes.
   always_ff @(posedge clk) begin
      if (reset) begin
         ext_dout <= '0;
      end else if (state == S_WAIT) begin
         ext_dout <= ram_dout;
      end
   end

   // Registered from the next state so it rises the cycle after the request
   // is seen and falls on the edge that returns to IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         pause_req <= 1'b0;
      end else begin
         pause_req <= (state_next != S_IDLE);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cpu_conflict <= 1'b0;
      end else if (ext_owns && cpu_we) begin
         cpu_conflict <= 1'b1;
      end
   end

endmodule
